regfile_sb: RTL and testbench
=============================

// Module: regfile_sb
// PURPOSE
//   Parametrised general-purpose register file for the pipelined core: 2 async read ports,
//   1 sync write port, optional write-to-read bypass, optional hardwired-zero R0, and a
//   per-register busy scoreboard for hazard detection. After reset, or a soft clear, a
//   sequential sweep zeroes every entry before the block reports ready. Decode reads it.
//   Writeback writes it.
// PARAMETERS
//   DATA_W   16  register width in bits
//   ADDR_W   3   address width; DEPTH = 2**ADDR_W entries
//   BYPASS   1   1 = same-cycle write data forwarded to matching read port
//   ZERO_R0  1   1 = entry 0 reads 0, ignores writes, never busy
// PORTS
//   clk       in   1       rising-edge clock; the block's only clock
//   rst       in   1       asynchronous reset, active-high
//   clr       in   1       soft clear request, sampled at posedge
//   rs1       in   ADDR_W  read address, port 1
//   rs2       in   ADDR_W  read address, port 2
//   rd1       out  DATA_W  read data, port 1 (combinational)
//   rd2       out  DATA_W  read data, port 2 (combinational)
//   we        in   1       write enable
//   ws        in   ADDR_W  write address
//   wd        in   DATA_W  write data
//   rsv_en    in   1       reserve: set busy[rsv_addr] (instruction issued with dest rsv_addr)
//   rsv_addr  in   ADDR_W  register to reserve
//   busy1     out  1       rs1 has a pending producer
//   busy2     out  1       rs2 has a pending producer
//   ready     out  1       1 = RUN state, accesses accepted
// BEHAVIOUR
//   FSM states CLEAR and RUN. Sweep counter cnt is ADDR_W bits wide.
//   rst=1 (async): state=CLEAR, cnt=0, all busy bits=0, ready=0. Array contents undefined
//     until the sweep completes.
//   CLEAR, each posedge: entry[cnt]<=0, cnt<=cnt+1.
//     When cnt==DEPTH-1, the next state is RUN.
//     Sweep takes exactly DEPTH cycles after rst falls. ready=1 on the first RUN cycle.
//   CLEAR: we, rsv_en and clr are ignored. rd1=rd2=0, busy1=busy2=0.
//   RUN + clr=1 at posedge: next state is CLEAR, cnt=0, all busy bits=0.
//     Any write or reserve in that same cycle is dropped.
//   Write (RUN): at posedge, entry[ws]<=wd if we. With ZERO_R0=1 and ws==0, the write is discarded.
//   Read, rdN for each port N:
//     ZERO_R0 && rsN==0                     -> 0
//     else BYPASS && we && ready && ws==rsN -> wd (same-cycle forward)
//     else                                  -> entry[rsN]
//   Scoreboard (RUN), at posedge:
//     we=1 clears busy[ws]; rsv_en=1 sets busy[rsv_addr].
//     Same address in one cycle: set wins (the new producer supersedes the old one).
//     ZERO_R0: busy[0] stays 0.
//   busyN = busy[rsN] && !(BYPASS && we && ws==rsN). A forwarded value is not a hazard.
//   Reserve is level-per-cycle, not counted: two reserves of one register need only one write to clear it.
//   rst asserted mid-sweep or mid-run: immediate return to CLEAR with cnt=0; the sweep restarts.
// TESTING
//   1. Pulse rst, DATA_W=16, ADDR_W=3 -> ready=0 for exactly 8 cycles, then 1; all 8 regs read 0.
//   2. we=1 ws=3 wd=16'hBEEF, rs1=3 same cycle -> rd1=BEEF (BYPASS=1); next cycle rd1=BEEF from
//      the array; with BYPASS=0, rd1=old value in the write cycle.
//   3. ZERO_R0=1: write ws=0 wd=16'h1234, and rsv_en with rsv_addr=0 -> rd1 at rs1=0 reads 0, busy1=0.
//   4. rsv_en rsv_addr=5 -> busy1=1 at rs1=5; in a later cycle, we ws=5 with rsv_en rsv_addr=5
//      -> busy stays 1; a following we alone -> busy1=0.
//   5. Write regs 1..7, then clr=1 -> ready=0 for 8 cycles, busy bits 0, all regs 0; we during the sweep is ignored.
//   6. Assert rst at sweep cycle 4 -> cnt restarts, ready rises 8 cycles after rst falls.

Source files
------------

// File: rtl/regfile_sb.sv
// regfile_sb: general-purpose register file for the pipelined core.
//
// Two combinational read ports, one synchronous write port, optional
// same-cycle write-to-read forwarding, optional hardwired-zero R0 and a
// per-register busy scoreboard. After reset or a soft clear, a sequential
// sweep zeroes every entry before ready is raised.
//
// States:
//   ST_CLEAR | sweeping entries to zero, accesses ignored, reads return 0
//   ST_RUN   | normal operation, ready_o = 1
//
// Ports:
//   clk_i       rising-edge clock
//   rst_i       asynchronous reset, active-high
//   clr_i       soft clear request (honoured in ST_RUN)
//   rs1_i/rs2_i read addresses
//   rd1_o/rd2_o read data (combinational)
//   we_i        write enable
//   ws_i/wd_i   write address / write data
//   rsv_en_i    reserve rsv_addr_i (destination of an issued instruction)
//   rsv_addr_i  register to mark busy
//   busy1_o/2_o read operand has a pending producer
//   ready_o     block is in ST_RUN
module regfile_sb #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 3,
    parameter bit BYPASS  = 1'b1,
    parameter bit ZERO_R0 = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic [ADDR_W-1:0] rs1_i,
    input  logic [ADDR_W-1:0] rs2_i,
    output logic [DATA_W-1:0] rd1_o,
    output logic [DATA_W-1:0] rd2_o,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] ws_i,
    input  logic [DATA_W-1:0] wd_i,
    input  logic              rsv_en_i,
    input  logic [ADDR_W-1:0] rsv_addr_i,
    output logic              busy1_o,
    output logic              busy2_o,
    output logic              ready_o
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [DEPTH-1:0]    busy_q, busy_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_data;

    assign ready_o = (state_q == ST_RUN);

    // State, sweep counter and scoreboard
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            busy_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    // Array contents are not reset; the sweep establishes them.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[mem_addr] <= mem_data;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        mem_we   = 1'b0;
        mem_addr = ws_i;
        mem_data = wd_i;

        if (state_q == ST_CLEAR) begin
            // Sweep one entry per cycle; we/rsv_en/clr are ignored here.
            mem_we   = 1'b1;
            mem_addr = cnt_q;
            mem_data = '0;
            cnt_d    = cnt_q + ADDR_W'(1);
            if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                state_d = ST_RUN;
            end
        end else begin
            if (clr_i) begin
                // Soft clear drops any write or reserve of this cycle.
                state_d = ST_CLEAR;
                cnt_d   = '0;
                busy_d  = '0;
            end else begin
                mem_we = we_i && !(ZERO_R0 && (ws_i == '0));
                if (we_i) begin
                    busy_d[ws_i] = 1'b0;
                end
                // Applied after the clear so a new producer supersedes the old one.
                if (rsv_en_i) begin
                    busy_d[rsv_addr_i] = 1'b1;
                end
                if (ZERO_R0) begin
                    busy_d[0] = 1'b0;
                end
            end
        end
    end

    function automatic logic fwd_hit(input logic [ADDR_W-1:0] a);
        return BYPASS && we_i && (ws_i == a);
    endfunction

    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] v;
        v = mem_q[a];
        if (!ready_o) begin
            v = '0;
        end else if (ZERO_R0 && (a == '0)) begin
            v = '0;
        end else if (fwd_hit(a)) begin
            v = wd_i;
        end
        return v;
    endfunction

    // A forwarded operand is not a hazard. busy_q is all-zero during the sweep.
    function automatic logic busy_port(input logic [ADDR_W-1:0] a);
        return busy_q[a] && !fwd_hit(a);
    endfunction

    always_comb begin
        rd1_o   = read_port(rs1_i);
        rd2_o   = read_port(rs2_i);
        busy1_o = busy_port(rs1_i);
        busy2_o = busy_port(rs2_i);
    end

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

    logic        clk_i = 1'b0;
    logic        rst_i, clr_i, we_i, rsv_en_i;
    logic [2:0]  rs1_i, rs2_i, ws_i, rsv_addr_i;
    logic [15:0] wd_i;

    logic [15:0] rd1_a, rd2_a, rd1_b, rd2_b;
    logic        busy1_a, busy2_a, ready_a, busy1_b, busy2_b, ready_b;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    // Instance a: defaults (BYPASS=1, ZERO_R0=1). Instance b: neither feature.
    regfile_sb dut_a (
        .clk_i(clk_i), .rst_i(rst_i), .clr_i(clr_i),
        .rs1_i(rs1_i), .rs2_i(rs2_i), .rd1_o(rd1_a), .rd2_o(rd2_a),
        .we_i(we_i), .ws_i(ws_i), .wd_i(wd_i),
        .rsv_en_i(rsv_en_i), .rsv_addr_i(rsv_addr_i),
        .busy1_o(busy1_a), .busy2_o(busy2_a), .ready_o(ready_a)
    );

    regfile_sb #(.BYPASS(1'b0), .ZERO_R0(1'b0)) dut_b (
        .clk_i(clk_i), .rst_i(rst_i), .clr_i(clr_i),
        .rs1_i(rs1_i), .rs2_i(rs2_i), .rd1_o(rd1_b), .rd2_o(rd2_b),
        .we_i(we_i), .ws_i(ws_i), .wd_i(wd_i),
        .rsv_en_i(rsv_en_i), .rsv_addr_i(rsv_addr_i),
        .busy1_o(busy1_b), .busy2_o(busy2_b), .ready_o(ready_b)
    );

    // ---------------- reference model ----------------
    bit          byp_cfg [2] = '{1'b1, 1'b0};
    bit          zr_cfg  [2] = '{1'b1, 1'b0};
    logic [15:0] m_mem   [2][8];
    bit          m_busy  [2][8];
    int          clear_left;   // sweep cycles still to go; 0 = running

    function automatic void wipe();
        clear_left = 8;
        for (int c = 0; c < 2; c++)
            for (int r = 0; r < 8; r++) begin
                m_mem[c][r]  = 16'h0;
                m_busy[c][r] = 1'b0;
            end
    endfunction

    function automatic void model_step();
        if (clear_left > 0) begin
            clear_left--;
        end else if (clr_i) begin
            wipe();
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (we_i && !(zr_cfg[c] && ws_i == 0)) m_mem[c][ws_i] = wd_i;
                if (we_i) m_busy[c][ws_i] = 1'b0;
                if (rsv_en_i) m_busy[c][rsv_addr_i] = 1'b1;
                if (zr_cfg[c]) m_busy[c][0] = 1'b0;
            end
        end
    endfunction

    function automatic logic [15:0] exp_rd(int c, logic [2:0] rs);
        if (clear_left > 0) return 16'h0;
        if (zr_cfg[c] && rs == 0) return 16'h0;
        if (byp_cfg[c] && we_i && ws_i == rs) return wd_i;
        return m_mem[c][rs];
    endfunction

    function automatic logic exp_busy(int c, logic [2:0] rs);
        if (clear_left > 0) return 1'b0;
        return m_busy[c][rs] && !(byp_cfg[c] && we_i && ws_i == rs);
    endfunction

    function automatic logic exp_ready();
        return clear_left == 0;
    endfunction

    // Inputs change 1 time unit after the edge; outputs are compared 2 later.
    task automatic tick();
        @(posedge clk_i);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        clr_i = 0; we_i = 0; rsv_en_i = 0;
        ws_i = 0; wd_i = 0; rsv_addr_i = 0; rs1_i = 0; rs2_i = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int n;
        rst_i = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk_i);
        #3;
        checks++;
        if ({ready_a, ready_b, busy1_a, busy1_b, rd1_a, rd1_b} !== 36'h0) begin
            errors++;
            $display("FAIL reset_state got ready=%b/%b busy=%b/%b rd=%h/%h want all 0",
                     ready_a, ready_b, busy1_a, busy1_b, rd1_a, rd1_b);
        end
        rst_i = 1'b0;
        wipe();
        n = 0;
        while (ready_a === 1'b0 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 8 || ready_b !== 1'b1) begin
            errors++;
            $display("FAIL reset_sweep_len got %0d cycles ready_b=%b want 8 cycles ready_b=1", n, ready_b);
        end
        for (int r = 0; r < 4; r++) begin
            rs1_i = 3'(r); rs2_i = 3'(r + 4);
            #2;
            checks++;
            if ({rd1_a, rd2_a, rd1_b, rd2_b} !== 64'h0) begin
                errors++;
                $display("FAIL reset_zero r%0d/r%0d got %h %h %h %h want 0", r, r + 4,
                         rd1_a, rd2_a, rd1_b, rd2_b);
            end
            tick();
        end
    endtask

    task automatic test_bypass();
        idle_inputs();
        we_i = 1; ws_i = 3; wd_i = 16'hBEEF; rs1_i = 3;
        #2;
        checks++;
        if (rd1_a !== 16'hBEEF || rd1_b !== 16'h0) begin
            errors++;
            $display("FAIL bypass_same_cycle got a=%h b=%h want a=beef b=0000", rd1_a, rd1_b);
        end
        tick();
        we_i = 0;
        #2;
        checks++;
        if (rd1_a !== 16'hBEEF || rd1_b !== 16'hBEEF) begin
            errors++;
            $display("FAIL bypass_next_cycle got a=%h b=%h want beef", rd1_a, rd1_b);
        end
        tick();
        we_i = 1; wd_i = 16'hCAFE; rs2_i = 3;
        #2;
        checks++;
        if (rd2_a !== 16'hCAFE || rd2_b !== 16'hBEEF) begin
            errors++;
            $display("FAIL bypass_overwrite got a=%h b=%h want a=cafe b=beef", rd2_a, rd2_b);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_zero_r0();
        idle_inputs();
        we_i = 1; ws_i = 0; wd_i = 16'h1234; rsv_en_i = 1; rsv_addr_i = 0; rs1_i = 0;
        #2;
        checks++;
        if (rd1_a !== 16'h0) begin
            errors++;
            $display("FAIL r0_forward got %h want 0000", rd1_a);
        end
        tick();
        idle_inputs();
        #2;
        checks++;
        if (rd1_a !== 16'h0 || busy1_a !== 1'b0 || rd1_b !== 16'h1234 || busy1_b !== 1'b1) begin
            errors++;
            $display("FAIL r0_hardwired got a=%h/%b b=%h/%b want a=0000/0 b=1234/1",
                     rd1_a, busy1_a, rd1_b, busy1_b);
        end
        we_i = 1; ws_i = 0; wd_i = 16'h0;   // release busy[0] in instance b
        tick();
        idle_inputs();
    endtask

    task automatic test_scoreboard();
        idle_inputs();
        rsv_en_i = 1; rsv_addr_i = 5; rs1_i = 5;
        tick();
        rsv_en_i = 0;
        #2;
        checks++;
        if (busy1_a !== 1'b1 || busy1_b !== 1'b1) begin
            errors++;
            $display("FAIL sb_reserve got %b/%b want 1/1", busy1_a, busy1_b);
        end
        tick();
        we_i = 1; ws_i = 5; wd_i = 16'(($urandom)); rsv_en_i = 1; rsv_addr_i = 5;
        #2;
        checks++;
        if (busy1_a !== 1'b0 || busy1_b !== 1'b1) begin
            errors++;
            $display("FAIL sb_forward_not_hazard got %b/%b want 0/1", busy1_a, busy1_b);
        end
        tick();
        we_i = 0; rsv_en_i = 0;
        #2;
        checks++;
        if (busy1_a !== 1'b1 || busy1_b !== 1'b1) begin
            errors++;
            $display("FAIL sb_set_wins got %b/%b want 1/1", busy1_a, busy1_b);
        end
        rsv_en_i = 1;       // second reserve of an already-busy register
        tick();
        rsv_en_i = 0; we_i = 1;
        tick();
        we_i = 0;
        #2;
        checks++;
        if (busy1_a !== 1'b0 || busy1_b !== 1'b0) begin
            errors++;
            $display("FAIL sb_single_release got %b/%b want 0/0", busy1_a, busy1_b);
        end
        tick();
    endtask

    task automatic test_clear();
        int n;
        idle_inputs();
        for (int r = 1; r < 8; r++) begin
            we_i = 1; ws_i = 3'(r); wd_i = 16'($urandom_range(1, 65535));
            rsv_en_i = 1; rsv_addr_i = 3'(r);
            tick();
        end
        idle_inputs();
        rs1_i = 2;
        #2;
        checks++;
        if (rd1_a !== m_mem[0][2] || busy1_a !== 1'b1) begin
            errors++;
            $display("FAIL clear_prefill got %h/%b want %h/1", rd1_a, busy1_a, m_mem[0][2]);
        end
        clr_i = 1; we_i = 1; ws_i = 6; wd_i = 16'h5A5A;
        tick();
        clr_i = 0;
        n = 0;
        while (ready_a === 1'b0 && n < 20) begin
            we_i = 1; ws_i = 3'($urandom); wd_i = 16'($urandom);
            rsv_en_i = 1; rsv_addr_i = 3'($urandom);
            rs1_i = ws_i; rs2_i = rsv_addr_i;
            clr_i = 1'($urandom);
            #2;
            checks++;
            if ({rd1_a, rd2_a, rd1_b, rd2_b, busy1_a, busy2_a, busy1_b, busy2_b, ready_b} !== 69'h0) begin
                errors++;
                $display("FAIL clear_sweep_quiet cyc%0d got %h %h %h %h busy=%b%b%b%b rdy_b=%b want 0",
                         n, rd1_a, rd2_a, rd1_b, rd2_b, busy1_a, busy2_a, busy1_b, busy2_b, ready_b);
            end
            tick();
            n++;
        end
        checks++;
        if (n !== 8) begin
            errors++;
            $display("FAIL clear_sweep_len got %0d want 8", n);
        end
        idle_inputs();
        for (int r = 0; r < 4; r++) begin
            rs1_i = 3'(r); rs2_i = 3'(r + 4);
            #2;
            checks++;
            if ({rd1_a, rd2_a, rd1_b, rd2_b, busy1_a, busy2_a, busy1_b, busy2_b} !== 68'h0) begin
                errors++;
                $display("FAIL clear_result r%0d/r%0d got %h %h %h %h busy=%b%b%b%b want 0",
                         r, r + 4, rd1_a, rd2_a, rd1_b, rd2_b, busy1_a, busy2_a, busy1_b, busy2_b);
            end
            tick();
        end
    endtask

    task automatic test_rst_mid_sweep();
        int n;
        idle_inputs();
        clr_i = 1;
        tick();
        clr_i = 0;
        repeat (4) tick();
        rst_i = 1;
        #1;
        checks++;
        if (ready_a !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_sweep_ready got %b want 0", ready_a);
        end
        #1;
        rst_i = 0;
        wipe();
        n = 0;
        while (ready_a === 1'b0 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 8) begin
            errors++;
            $display("FAIL rst_mid_sweep_len got %0d want 8", n);
        end
    endtask

    task automatic test_random();
        logic [35:0] got, want;
        idle_inputs();
        for (int i = 0; i < 400; i++) begin
            we_i       = 1'($urandom);
            ws_i       = 3'($urandom);
            wd_i       = 16'($urandom);
            rsv_en_i   = 1'($urandom);
            rsv_addr_i = 3'($urandom);
            rs1_i      = 3'($urandom);
            rs2_i      = ($urandom_range(0, 3) == 0) ? ws_i : 3'($urandom);
            clr_i      = ($urandom_range(0, 39) == 0);
            #2;
            for (int c = 0; c < 2; c++) begin
                got  = (c == 0) ? {rd1_a, rd2_a, busy1_a, busy2_a, ready_a, 1'b0}
                                : {rd1_b, rd2_b, busy1_b, busy2_b, ready_b, 1'b0};
                want = {exp_rd(c, rs1_i), exp_rd(c, rs2_i), exp_busy(c, rs1_i),
                        exp_busy(c, rs2_i), exp_ready(), 1'b0};
                checks++;
                if (got !== want) begin
                    errors++;
                    $display("FAIL random_%0s it%0d rs=%0d,%0d got %h want %h",
                             (c == 0) ? "a" : "b", i, rs1_i, rs2_i, got, want);
                end
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_zero_r0();
        test_scoreboard();
        test_clear();
        test_rst_mid_sweep();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
